piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in/serial-out transmitter. It is the sending end of the team's 8-bit serial shift link. A word is accepted over a valid/ready handshake and shifted out MSB first, one bit per bit period. It is ordered so that a serial-in/parallel-out receiver on the same clock, enabled by frame, reassembles the word with bit order preserved. A one-word holding buffer allows back-to-back words with no idle gap on the line.

Parameters:
WIDTH, 8, word width in bits (≥2)
CLKS_PER_BIT, 1, clk cycles each serial bit is held (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
dataIn  in  WIDTH  parallel word to send
load  in  1  valid; word accepted at an edge where load && ready
ready  out  1  transmitter can accept a word this cycle
dataOut  out  1  serial data, MSB first
frame  out  1  high while dataOut carries a data bit
done  out  1  one-cycle pulse after the last bit of each word
busy  out  1  high while in SHIFT

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Cycle numbering: "cycle k" is the interval following rising edge k.
- Reset: while rst is sampled high, the next cycle has dataOut=0, frame=0, done=0, busy=0. Holding buffer and counters are cleared, and state is IDLE.
- ready is combinational: !rst && !holdFull. It is 0 while rst is high and 1 in the first cycle after reset.
- Registers:
  - shift register, WIDTH bits
  - holding register plus holdFull flag
  - bit counter, clog2(WIDTH) bits, counts WIDTH-1 down to 0
  - divider counter, counts CLKS_PER_BIT-1 down to 0; no divider cycles when CLKS_PER_BIT=1
- All outputs except ready are registered.
- States: IDLE, SHIFT.
- IDLE:
  - dataOut=0, frame=0, busy=0.
  - A load accepted at edge N bypasses the holding register and goes straight into the shift register.
  - State becomes SHIFT. MSB is on dataOut with frame=1 in cycle N.
- SHIFT:
  - Each bit is held for CLKS_PER_BIT cycles, then the register shifts left and the next bit appears.
  - Bit i (MSB=0) occupies cycles N+i*CLKS_PER_BIT through N+(i+1)*CLKS_PER_BIT-1.
- Load during SHIFT: when hold is empty, an accepted word goes to the holding register and holdFull is set. ready is low from the next cycle.
- End of word: at the edge ending the last bit period, done=1 for exactly one cycle. Then:
  - if holdFull: move hold into the shift register; holdFull clears, ready returns to 1, stay in SHIFT, frame stays high with no gap
  - else if load && ready at that same edge: new word bypasses into the shift register, no gap
  - else: go to IDLE; dataOut=0, frame=0, busy=0
- load while ready=0: ignored. No state change, data is dropped.
- dataIn is sampled only at the accept edge. Later changes have no effect.
- Reset mid-word: transmission aborts and any held word is discarded. No done pulse is generated.
- done coincides with the first bit of the next word when words run back-to-back.

Test Plan:
1. rst high for 2 cycles with load=1 -> during reset ready=0; afterwards dataOut=0, frame=0, done=0, busy=0, ready=1; nothing transmitted.
2. CLKS_PER_BIT=1, load 8'hA5 at edge N -> dataOut 1,0,1,0,0,1,0,1 in cycles N..N+7; frame=1 exactly those cycles; done=1 only in cycle N+8; a looped-back SIPO enabled by frame holds 8'hA5.
3. Load 8'h3C at edge N, 8'hC3 at edge N+1 -> ready=0 in cycles N+1..N+7, 1 from N+8; frame high for 16 contiguous cycles; bits 00111100 then 11000011; done in cycles N+8 and N+16.
4. As test 3, plus load 8'hFF held high in cycles N+1..N+7 -> ignored while ready=0; only 8'h3C and 8'hC3 are sent.
5. CLKS_PER_BIT=4, load 8'h81 at edge N -> dataOut=1 in cycles N..N+3, 0 in N+4..N+27, 1 in N+28..N+31; frame high for 32 cycles; done in cycle N+32.
6. Send 8'hFF with 8'h00 held; assert rst during cycle N+3 -> from cycle N+4 all outputs are 0 and ready=1, with no done pulse; then 8'h01 loaded at edge M transmits 00000001 in cycles M..M+7 with done in cycle M+8.

Source files
------------

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle of the piso_tx transmitter.
// The master side offers words; the slave side is the transmitter itself.
interface piso_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] dataIn;
  logic             load;
  logic             ready;
  logic             dataOut;
  logic             frame;
  logic             done;
  logic             busy;

  modport master (output dataIn, load, input ready, dataOut, frame, done, busy);
  modport slave  (input dataIn, load, output ready, dataOut, frame, done, busy);
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, MSB first. A one-word holding buffer
// lets consecutive words follow each other on the line without a gap.
module piso_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [BW-1:0]    bitcnt;
  logic [DW-1:0]    divcnt;

  logic             accept;
  logic             bit_end;
  logic             word_end;
  logic [WIDTH-1:0] next_word;

  assign bus.ready = !rst && !hold_full;
  assign accept    = bus.load && bus.ready;
  assign bit_end   = (divcnt == '0);
  assign word_end  = bit_end && (bitcnt == '0);
  // A held word always goes out before a freshly offered one; when hold is
  // empty the incoming word bypasses it.
  assign next_word = hold_full ? hold : bus.dataIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bitcnt      <= '0;
      divcnt      <= '0;
      bus.dataOut <= 1'b0;
      bus.frame   <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            sreg        <= next_word;
            bus.dataOut <= next_word[WIDTH-1];
            bus.frame   <= 1'b1;
            bus.busy    <= 1'b1;
            bitcnt      <= BIT_LAST;
            divcnt      <= DIV_LAST;
          end
        end
        SHIFT: begin
          if (!bit_end) begin
            divcnt <= divcnt - 1'b1;
          end else if (!word_end) begin
            sreg        <= sreg << 1;
            bus.dataOut <= sreg[WIDTH-2];
            bitcnt      <= bitcnt - 1'b1;
            divcnt      <= DIV_LAST;
          end else begin
            bus.done <= 1'b1;
            if (hold_full || accept) begin
              sreg        <= next_word;
              bus.dataOut <= next_word[WIDTH-1];
              bitcnt      <= BIT_LAST;
              divcnt      <= DIV_LAST;
              hold_full   <= 1'b0;
            end else begin
              state       <= IDLE;
              bus.dataOut <= 1'b0;
              bus.frame   <= 1'b0;
              bus.busy    <= 1'b0;
            end
          end
          // Mid-word accepts park in hold; at word end they bypassed above.
          if (accept && !word_end) begin
            hold      <= bus.dataIn;
            hold_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (1 and 4 clocks per bit) checked every
// cycle against a line-queue model, plus directed literal expectations.
module tb_piso_tx;
  localparam int W     = 8;
  localparam int DEPTH = 64;

  typedef struct packed { logic b; logic last; } line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) b1 ();
  piso_tx_if #(.WIDTH(W)) b4 ();

  piso_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  piso_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  int checks = 0;
  int errors = 0;

  // Model: each accepted word becomes W*cpb line slots queued in a ring;
  // one slot is consumed per cycle. The transmitter can take another word
  // whenever less than one full word is still queued behind the current slot.
  line_t ring [2][DEPTH];
  int    head [2];
  int    cnt  [2];
  line_t cur  [2];
  bit    cur_v [2];
  bit    e_done [2];
  bit    mvalid = 1'b0;
  logic [W-1:0] sipo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int cpb;
      int len;
      logic ld;
      logic [W-1:0] d;
      cpb = (k == 0) ? 1 : 4;
      len = W * cpb;
      ld  = (k == 0) ? b1.load : b4.load;
      d   = (k == 0) ? b1.dataIn : b4.dataIn;
      if (rst) begin
        cnt[k]    = 0;
        head[k]   = 0;
        cur_v[k]  = 1'b0;
        e_done[k] = 1'b0;
        mvalid    = 1'b1;
      end else begin
        e_done[k] = cur_v[k] && cur[k].last;
        if (ld === 1'b1 && cnt[k] < len) begin
          for (int i = 0; i < W; i++)
            for (int c = 0; c < cpb; c++) begin
              ring[k][(head[k] + cnt[k]) % DEPTH] = {d[W-1-i], (i == W-1 && c == cpb-1)};
              cnt[k]++;
            end
        end
        cur_v[k] = (cnt[k] > 0);
        if (cur_v[k]) begin
          cur[k]  = ring[k][head[k]];
          head[k] = (head[k] + 1) % DEPTH;
          cnt[k]--;
        end
      end
    end
  end

  task automatic cmp(input int k, input string p, input logic dout, input logic frm,
                     input logic dn, input logic bsy, input logic rdy);
    int len;
    len = (k == 0) ? W : 4 * W;
    chk({p, ".dataOut"}, dout, cur_v[k] ? cur[k].b : 1'b0);
    chk({p, ".frame"},   frm,  cur_v[k]);
    chk({p, ".busy"},    bsy,  cur_v[k]);
    chk({p, ".done"},    dn,   e_done[k]);
    chk({p, ".ready"},   rdy,  !rst && (cnt[k] < len));
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (mvalid) begin
      cmp(0, "m1", b1.dataOut, b1.frame, b1.done, b1.busy, b1.ready);
      cmp(1, "m4", b4.dataOut, b4.frame, b4.done, b4.busy, b4.ready);
    end
  end

  // Receiver stand-in for the 1-clock instance: shifts while frame is high.
  initial forever begin
    @(negedge clk);
    if (b1.frame === 1'b1) sipo = {sipo[W-2:0], b1.dataOut};
  end

  // Single word on the 1-clock instance, starting from idle.
  task automatic send1(input logic [W-1:0] w, input string p);
    logic [W-1:0] v;
    logic [W:0]   f;
    logic [W:0]   d;
    v = '0;
    b1.dataIn = w;
    b1.load   = 1'b1;
    @(negedge clk);
    b1.load   = 1'b0;
    b1.dataIn = ~w;
    for (int i = 0; i <= W; i++) begin
      if (i < W) v = {v[W-2:0], b1.dataOut};
      f[i] = b1.frame;
      d[i] = b1.done;
      @(negedge clk);
    end
    chk({p, ".bits"},  v, w);
    chk({p, ".frame"}, f, 9'h0FF);
    chk({p, ".done"},  d, 9'h100);
    chk({p, ".sipo"},  sipo, w);
  endtask

  // Back-to-back 3C then C3; optionally FF offered while hold is full.
  task automatic pair(input bit ff, input string p);
    logic [15:0] v;
    logic [16:0] f;
    logic [16:0] d;
    logic [16:0] r;
    b1.dataIn = 8'h3C;
    b1.load   = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      #1;
      if (i < 16) v[15-i] = b1.dataOut;
      f[i] = b1.frame;
      d[i] = b1.done;
      r[i] = b1.ready;
      if (i == 0) begin
        b1.dataIn = 8'hC3;
        b1.load   = 1'b1;
      end else if (i <= 7) begin
        b1.dataIn = 8'hFF;
        b1.load   = ff;
      end else begin
        b1.load   = 1'b0;
      end
      @(negedge clk);
    end
    chk({p, ".bits"},  v, 16'h3CC3);
    chk({p, ".frame"}, f, 17'h0FFFF);
    chk({p, ".done"},  d, 17'h10100);
    chk({p, ".ready"}, r, 17'h1FF01);
  endtask

  initial begin
    logic [32:0] a;
    logic [32:0] f;
    logic [32:0] d;

    // Reset with load held high.
    rst = 1'b1;
    b1.load = 1'b1; b1.dataIn = 8'hA5;
    b4.load = 1'b1; b4.dataIn = 8'h81;
    @(negedge clk); #1;
    chk("t1.ready_rst1", b1.ready, 1'b0);
    @(negedge clk); #1;
    chk("t1.ready_rst4", b4.ready, 1'b0);
    rst = 1'b0;
    b1.load = 1'b0;
    b4.load = 1'b0;
    #1;
    chk("t1.ready",   b1.ready,   1'b1);
    chk("t1.dataOut", b1.dataOut, 1'b0);
    chk("t1.frame",   b1.frame,   1'b0);
    chk("t1.done",    b1.done,    1'b0);
    chk("t1.busy",    b1.busy,    1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("t1.idle_frame", b1.frame, 1'b0);
    chk("t1.idle_frame4", b4.frame, 1'b0);

    // 4 clocks per bit, 81.
    b4.dataIn = 8'h81;
    b4.load   = 1'b1;
    @(negedge clk);
    b4.load   = 1'b0;
    b4.dataIn = 8'h00;
    for (int i = 0; i <= 32; i++) begin
      #1;
      a[i] = b4.dataOut;
      f[i] = b4.frame;
      d[i] = b4.done;
      @(negedge clk);
    end
    chk("t5.dataOut", a, 33'h0F000000F);
    chk("t5.frame",   f, 33'h0FFFFFFFF);
    chk("t5.done",    d, 33'h100000000);

    send1(8'hA5, "t2");
    repeat (2) @(negedge clk);
    pair(1'b0, "t3");
    repeat (2) @(negedge clk);
    pair(1'b1, "t4");
    repeat (2) @(negedge clk);

    // Reset in the middle of FF with 00 held.
    b1.dataIn = 8'hFF;
    b1.load   = 1'b1;
    @(negedge clk);
    b1.dataIn = 8'h00;
    @(negedge clk);
    b1.load   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6.dataOut", b1.dataOut, 1'b0);
    chk("t6.frame",   b1.frame,   1'b0);
    chk("t6.done",    b1.done,    1'b0);
    chk("t6.busy",    b1.busy,    1'b0);
    chk("t6.ready",   b1.ready,   1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("t6.no_done",  b1.done,  1'b0);
      chk("t6.no_frame", b1.frame, 1'b0);
    end
    send1(8'h01, "t6b");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
